seq_match_fifo: RTL and testbench
=================================

// Module: seq_match_fifo
// PURPOSE
// - Downstream stage of the sequence detector: captures every detected nibble (OUT_VALID/DATA_OUT) plus the
//   MODE active at detection, buffers it in a small FIFO, and offers it to a consumer via valid/ready.
// - Decouples the detector (no back-pressure, one match per cycle max) from a slower reader; flags loss.
// PARAMETERS
// - DEPTH   8   FIFO entries; power of two, 2..64
// - AW      3   pointer width = log2(DEPTH); FIFO_CNT is AW+1 bits
// PORTS
// - SYSCLK      in   1     system clock, all logic on rising edge
// - RST_B       in   1     asynchronous active-low reset
// - MATCH_VALID in   1     detector OUT_VALID; 1-cycle pulse per match
// - MATCH_DATA  in   4     detector DATA_OUT, sampled when MATCH_VALID=1
// - MODE        in   2     detector MODE; stored with each entry
// - RD_READY    in   1     consumer ready
// - OVF_CLR     in   1     clears sticky OVERFLOW
// - RD_VALID    out  1     head entry available
// - RD_DATA     out  6     {mode[1:0], data[3:0]} of head entry; 6'h00 when RD_VALID=0
// - FIFO_CNT    out  AW+1  entries held, 0..DEPTH
// - FULL        out  1     FIFO_CNT==DEPTH
// - OVERFLOW    out  1     sticky: a match was dropped
// BEHAVIOUR
// - Reset (async, RST_B=0): wr_ptr=rd_ptr=0, FIFO_CNT=0, RD_VALID=0, RD_DATA=0, FULL=0, OVERFLOW=0.
//   Storage array not reset. Reset mid-transfer discards all contents immediately.
// - Push: MATCH_VALID=1 and MODE!=2'b11 and (!FULL or pop this cycle). Entry {MODE,MATCH_DATA} -> mem[wr_ptr].
//   MATCH_VALID with MODE==2'b11 ignored (detector idle mode): no push, no overflow.
// - Pop: RD_VALID && RD_READY; rd_ptr advances on that edge.
// - Show-ahead: RD_VALID = (FIFO_CNT!=0), RD_DATA = mem[rd_ptr] gated by RD_VALID; no comb path input->output.
// - Latency: push at edge N -> RD_VALID=1 after edge N (visible cycle N+1). No empty bypass.
// - Pointers AW bits, wrap DEPTH-1 -> 0 naturally. FIFO_CNT: +1 push only, -1 pop only, unchanged both/neither.
// - Full + push + pop same cycle: both occur, FIFO_CNT stays DEPTH, no overflow.
// - Full + push, no pop: entry dropped, contents untouched, OVERFLOW<=1.
// - Empty + RD_READY: no pop, pointers unchanged.
// - OVERFLOW: set by drop, cleared by OVF_CLR; drop and OVF_CLR same cycle -> stays 1 (set wins).
// - No internal FSM beyond pointer/count state; all outputs registered or decoded from registers.
// CONFIGURATION
// - SEQ_MATCH_FIFO_STATS_EN defined: adds output MATCH_CNT[7:0] and input STATS_CLR.
//   MATCH_CNT counts accepted pushes, saturates at 8'hFF, reset to 0 by RST_B or STATS_CLR
//   (STATS_CLR wins over same-cycle push). Drops not counted.
// - Not defined: ports and counter absent; remaining behaviour identical.
// TESTING
// - Reset, idle: RST_B low then high, no stimulus -> RD_VALID=0, RD_DATA=0, FIFO_CNT=0, FULL=0, OVERFLOW=0.
// - Single match: MODE=0, MATCH_VALID pulse DATA=4'h5, RD_READY=0 -> next cycle RD_VALID=1, RD_DATA=6'h05,
//   FIFO_CNT=1; RD_READY=1 one cycle -> FIFO_CNT=0, RD_VALID=0.
// - Fill/overflow (DEPTH=8): 9 pushes DATA=0..8 MODE=1, RD_READY=0 -> FULL=1, FIFO_CNT=8, OVERFLOW=1;
//   drain reads 6'h10..6'h17 in order, value 8 absent; OVF_CLR pulse -> OVERFLOW=0.
// - Full push+pop: FIFO full, push DATA=4'hA MODE=2 with RD_READY=1 -> FIFO_CNT stays 8, OVERFLOW=0,
//   6'h2A read last; pointers wrap correctly over 3 full fill/drain rounds.
// - Mode 3 / reset mid-op: push with MODE=3 -> FIFO_CNT unchanged; with 4 entries held assert RST_B=0
//   mid-cycle -> RD_VALID, FIFO_CNT drop to 0 immediately.
// - Stats (SEQ_MATCH_FIFO_STATS_EN): 300 pushes with concurrent pops -> MATCH_CNT=8'hFF; STATS_CLR with
//   same-cycle push -> MATCH_CNT=0.

Source files
------------

// File: rtl/seq_match_fifo.sv
// Match capture FIFO: buffers {mode, nibble} from the sequence detector for a valid/ready consumer.
// Optional match statistics counter enabled by defining SEQ_MATCH_FIFO_STATS_EN.
module seq_match_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          SYSCLK,
  input  logic          RST_B,
  input  logic          MATCH_VALID,
  input  logic [3:0]    MATCH_DATA,
  input  logic [1:0]    MODE,
  input  logic          RD_READY,
  input  logic          OVF_CLR,
`ifdef SEQ_MATCH_FIFO_STATS_EN
  input  logic          STATS_CLR,
  output logic [7:0]    MATCH_CNT,
`endif
  output logic          RD_VALID,
  output logic [5:0]    RD_DATA,
  output logic [AW:0]   FIFO_CNT,
  output logic          FULL,
  output logic          OVERFLOW
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          overflow_q;

  logic          rd_valid;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;

  assign rd_valid = (fifo_cnt != '0);
  assign full     = (fifo_cnt == FULL_CNT);
  // Mode 3 is the detector's idle mode; its matches are neither stored nor treated as lost.
  assign push_req = MATCH_VALID && (MODE != 2'b11);
  assign pop      = rd_valid && RD_READY;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge SYSCLK) begin
    if (push) begin
      mem[wr_ptr] <= {MODE, MATCH_DATA};
    end
  end

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A drop in the same cycle as a clear must remain visible, so set takes priority.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (OVF_CLR) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef SEQ_MATCH_FIFO_STATS_EN
  logic [7:0] match_cnt;

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      match_cnt <= '0;
    end else if (STATS_CLR) begin
      match_cnt <= '0;
    end else if (push && (match_cnt != 8'hFF)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

  assign MATCH_CNT = match_cnt;
`endif

  assign RD_VALID = rd_valid;
  assign RD_DATA  = rd_valid ? mem[rd_ptr] : 6'h00;
  assign FIFO_CNT = fifo_cnt;
  assign FULL     = full;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_seq_match_fifo.sv
// Directed bench for seq_match_fifo with a queue scoreboard of expected read entries.
// Stats checks are compiled in when SEQ_MATCH_FIFO_STATS_EN is defined.
module tb_seq_match_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          SYSCLK;
  logic          RST_B;
  logic          MATCH_VALID;
  logic [3:0]    MATCH_DATA;
  logic [1:0]    MODE;
  logic          RD_READY;
  logic          OVF_CLR;
  logic          STATS_CLR;
  logic [7:0]    MATCH_CNT;
  logic          RD_VALID;
  logic [5:0]    RD_DATA;
  logic [AW:0]   FIFO_CNT;
  logic          FULL;
  logic          OVERFLOW;

  seq_match_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .SYSCLK      (SYSCLK),
    .RST_B       (RST_B),
    .MATCH_VALID (MATCH_VALID),
    .MATCH_DATA  (MATCH_DATA),
    .MODE        (MODE),
    .RD_READY    (RD_READY),
    .OVF_CLR     (OVF_CLR),
`ifdef SEQ_MATCH_FIFO_STATS_EN
    .STATS_CLR   (STATS_CLR),
    .MATCH_CNT   (MATCH_CNT),
`endif
    .RD_VALID    (RD_VALID),
    .RD_DATA     (RD_DATA),
    .FIFO_CNT    (FIFO_CNT),
    .FULL        (FULL),
    .OVERFLOW    (OVERFLOW)
  );

`ifndef SEQ_MATCH_FIFO_STATS_EN
  assign MATCH_CNT = 8'h00;
`endif

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int         n_vec  = 0;
  int         n_err  = 0;
  logic [5:0] sb[$];
  int         m_cnt  = 0;
  logic       m_ovf  = 1'b0;
  int         m_stat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check read side before the edge, state after it.
  task automatic step(input logic mv, input logic [3:0] md, input logic [1:0] mo,
                      input logic rdy, input logic oclr, input logic sclr);
    logic       exp_pop;
    logic       exp_push;
    logic       req;
    logic [5:0] exp_data;
    @(negedge SYSCLK);
    MATCH_VALID = mv;
    MATCH_DATA  = md;
    MODE        = mo;
    RD_READY    = rdy;
    OVF_CLR     = oclr;
    STATS_CLR   = sclr;
    #1;
    chk("rd_valid", {31'd0, RD_VALID}, {31'd0, (m_cnt != 0)});
    exp_pop = (m_cnt != 0) && rdy;
    if (exp_pop) begin
      exp_data = sb.pop_front();
      chk("rd_data", {26'd0, RD_DATA}, {26'd0, exp_data});
    end else if (m_cnt == 0) begin
      chk("rd_data_empty", {26'd0, RD_DATA}, 32'd0);
    end
    req      = mv && (mo != 2'b11);
    exp_push = req && ((m_cnt < DEPTH) || exp_pop);
    if (exp_push) sb.push_back({mo, md});
    if (req && !exp_push) m_ovf = 1'b1;
    else if (oclr)        m_ovf = 1'b0;
    if (exp_push && !exp_pop) m_cnt++;
    else if (exp_pop && !exp_push) m_cnt--;
    if (sclr) m_stat = 0;
    else if (exp_push && m_stat < 255) m_stat++;
    @(posedge SYSCLK);
    #1;
    chk("fifo_cnt", {28'd0, FIFO_CNT}, m_cnt);
    chk("full", {31'd0, FULL}, {31'd0, (m_cnt == DEPTH)});
    chk("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
`ifdef SEQ_MATCH_FIFO_STATS_EN
    chk("match_cnt", {24'd0, MATCH_CNT}, m_stat);
`endif
  endtask

  initial begin
    RST_B       = 1'b0;
    MATCH_VALID = 1'b0;
    MATCH_DATA  = 4'h0;
    MODE        = 2'b00;
    RD_READY    = 1'b0;
    OVF_CLR     = 1'b0;
    STATS_CLR   = 1'b0;

    // reset / idle
    repeat (3) @(posedge SYSCLK);
    #1;
    chk("rst_rd_valid", {31'd0, RD_VALID}, 32'd0);
    chk("rst_rd_data", {26'd0, RD_DATA}, 32'd0);
    chk("rst_fifo_cnt", {28'd0, FIFO_CNT}, 32'd0);
    chk("rst_full", {31'd0, FULL}, 32'd0);
    chk("rst_overflow", {31'd0, OVERFLOW}, 32'd0);
    @(negedge SYSCLK);
    RST_B = 1'b1;
    repeat (2) step(0, 4'h0, 2'd0, 0, 0, 0);

    // single match then one read
    step(1, 4'h5, 2'd0, 0, 0, 0);
    chk("single_data", {26'd0, RD_DATA}, 32'h05);
    chk("single_valid", {31'd0, RD_VALID}, 32'd1);
    step(0, 4'h0, 2'd0, 1, 0, 0);
    chk("single_empty", {31'd0, RD_VALID}, 32'd0);

    // fill past full: 8 stored, 9th dropped
    for (int i = 0; i < 9; i++) step(1, 4'(i), 2'd1, 0, 0, 0);
    chk("fill_full", {31'd0, FULL}, 32'd1);
    chk("fill_cnt", {28'd0, FIFO_CNT}, 32'd8);
    chk("fill_ovf", {31'd0, OVERFLOW}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 4'h0, 2'd0, 1, 0, 0);
    chk("drain_empty", {31'd0, RD_VALID}, 32'd0);
    step(0, 4'h0, 2'd0, 0, 1, 0);
    chk("ovf_clr", {31'd0, OVERFLOW}, 32'd0);

    // drop and clear together: overflow stays set
    for (int i = 0; i < DEPTH; i++) step(1, 4'(i), 2'd0, 0, 0, 0);
    step(1, 4'hF, 2'd0, 0, 1, 0);
    chk("ovf_set_wins", {31'd0, OVERFLOW}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 4'h0, 2'd0, 1, 0, 0);
    step(0, 4'h0, 2'd0, 0, 1, 0);

    // full push+pop, three rounds to exercise pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) step(1, 4'((r * 3 + i) & 15), 2'(r % 3), 0, 0, 0);
      step(1, 4'hA, 2'd2, 1, 0, 0);
      chk("fullpp_cnt", {28'd0, FIFO_CNT}, 32'd8);
      chk("fullpp_ovf", {31'd0, OVERFLOW}, 32'd0);
      for (int i = 0; i < DEPTH; i++) step(0, 4'h0, 2'd0, 1, 0, 0);
    end

    // mode 3 ignored
    step(1, 4'h7, 2'd3, 0, 0, 0);
    chk("mode3_cnt", {28'd0, FIFO_CNT}, 32'd0);
    chk("mode3_ovf", {31'd0, OVERFLOW}, 32'd0);

    // pseudo-random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'b0);
    while (m_cnt != 0) step(0, 4'h0, 2'd0, 1, 0, 0);

    // reset mid-cycle with 4 entries held
    for (int i = 0; i < 4; i++) step(1, 4'(i + 3), 2'd1, 0, 0, 0);
    chk("pre_rst_cnt", {28'd0, FIFO_CNT}, 32'd4);
    @(negedge SYSCLK);
    MATCH_VALID = 1'b0;
    #2;
    RST_B = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, RD_VALID}, 32'd0);
    chk("midrst_cnt", {28'd0, FIFO_CNT}, 32'd0);
    chk("midrst_data", {26'd0, RD_DATA}, 32'd0);
    sb.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_stat = 0;
    @(negedge SYSCLK);
    RST_B = 1'b1;
    step(0, 4'h0, 2'd0, 1, 0, 0);
    step(1, 4'h9, 2'd2, 0, 0, 0);
    step(0, 4'h0, 2'd0, 1, 0, 0);

`ifdef SEQ_MATCH_FIFO_STATS_EN
    // saturating match counter, then clear beating a push
    for (int i = 0; i < 300; i++) step(1, 4'(i & 15), 2'd0, 1, 0, 0);
    chk("stats_sat", {24'd0, MATCH_CNT}, 32'hFF);
    step(1, 4'h1, 2'd0, 1, 0, 1);
    chk("stats_clr", {24'd0, MATCH_CNT}, 32'd0);
    while (m_cnt != 0) step(0, 4'h0, 2'd0, 1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
